// File: rtl/rgb_pwm_gen_pkg.sv
// rgb_pwm_gen_pkg: shared constants for the RGB PWM generator.
// Holds the default counter width and the PWM output levels.
// Optional macro RGB_PWM_ACTIVE_LOW_EN: when defined, the PWM pins are
// active-low (common-anode LED); otherwise they are active-high.
package rgb_pwm_gen_pkg;

   localparam int CNT_W_DEF = 32;

`ifdef RGB_PWM_ACTIVE_LOW_EN
   localparam logic PWM_ACTIVE   = 1'b0;
`else
   localparam logic PWM_ACTIVE   = 1'b1;
`endif
   localparam logic PWM_INACTIVE = ~PWM_ACTIVE;

   // Operating mode, derived from the period shadow register
   typedef enum logic {
      MODE_IDLE = 1'b0,
      MODE_RUN  = 1'b1
   } mode_e;

   // Map a logical "channel on" flag onto the pin level
   function automatic logic pwm_level(input logic active);
      return active ? PWM_ACTIVE : PWM_INACTIVE;
   endfunction

endpackage

// File: rtl/rgb_pwm_gen_channel.sv
// pwm_channel: one PWM channel of rgb_pwm_gen.
// Keeps the duty shadow register, compares it with the shared period
// counter and registers the result with the configured pin polarity.
// Polarity follows RGB_PWM_ACTIVE_LOW_EN through rgb_pwm_gen_pkg.
module pwm_channel
   import rgb_pwm_gen_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             CLK,
   input  logic             RST_n,
   input  logic [CNT_W-1:0] i_duty,
   input  logic [CNT_W-1:0] i_cnt,
   input  logic             i_load,
   input  logic             i_idle,
   output logic             o_pwm
);

   logic [CNT_W-1:0] r_duty_sh;
   logic             r_pwm;
   logic             w_on;

   // Duty >= period saturates naturally: cnt never reaches the duty value
   assign w_on = !i_idle && (i_cnt < r_duty_sh);

   // Duty shadow reloads only at a wrap or while idle, so bus writes never cut a pulse
   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         r_duty_sh <= '0;
      end else if (i_load) begin
         r_duty_sh <= i_duty;
      end
   end

   // Registered compare output with pin polarity applied
   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         r_pwm <= PWM_INACTIVE;
      end else begin
         r_pwm <= pwm_level(w_on);
      end
   end

   assign o_pwm = r_pwm;

endmodule

// File: rtl/rgb_pwm_gen.sv
// rgb_pwm_gen: three-channel PWM generator for the RGB LED.
// Owns the period counter, period shadow, wrap detection and PERIOD_TICK;
// three pwm_channel instances share the counter, wrap strobe and idle flag.
// Optional macro RGB_PWM_ACTIVE_LOW_EN inverts the PWM pins (PERIOD_TICK unaffected).
module rgb_pwm_gen
   import rgb_pwm_gen_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             CLK,
   input  logic             RST_n,
   input  logic [CNT_W-1:0] PERIOD_Qin,
   input  logic [CNT_W-1:0] DUTY_R_Qin,
   input  logic [CNT_W-1:0] DUTY_G_Qin,
   input  logic [CNT_W-1:0] DUTY_B_Qin,
   output logic             PWM_R,
   output logic             PWM_G,
   output logic             PWM_B,
   output logic             PERIOD_TICK
);

   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] r_period_sh;
   logic             r_tick;

   mode_e            w_mode;
   logic             w_idle;
   logic             w_wrap;
   logic             w_load;

   assign w_mode = (r_period_sh == '0) ? MODE_IDLE : MODE_RUN;
   assign w_idle = (w_mode == MODE_IDLE);
   assign w_wrap = !w_idle && (r_cnt == (r_period_sh - CNT_W'(1)));
   // Shadows track the inputs every cycle while idle, otherwise only at a wrap
   assign w_load = w_idle || w_wrap;

   // Period counter: held at 0 while idle, wraps after period_sh-1
   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         r_cnt <= '0;
      end else if (w_load) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   // Period shadow register; a 0 loaded at a wrap drops the block into idle
   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         r_period_sh <= '0;
      end else if (w_load) begin
         r_period_sh <= PERIOD_Qin;
      end
   end

   // One-cycle tick registered from the wrap strobe (constant 1 when period is 1)
   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         r_tick <= 1'b0;
      end else begin
         r_tick <= w_wrap;
      end
   end

   assign PERIOD_TICK = r_tick;

   pwm_channel #(.CNT_W(CNT_W)) u_ch_r (
      .CLK    (CLK),
      .RST_n  (RST_n),
      .i_duty (DUTY_R_Qin),
      .i_cnt  (r_cnt),
      .i_load (w_load),
      .i_idle (w_idle),
      .o_pwm  (PWM_R)
   );

   pwm_channel #(.CNT_W(CNT_W)) u_ch_g (
      .CLK    (CLK),
      .RST_n  (RST_n),
      .i_duty (DUTY_G_Qin),
      .i_cnt  (r_cnt),
      .i_load (w_load),
      .i_idle (w_idle),
      .o_pwm  (PWM_G)
   );

   pwm_channel #(.CNT_W(CNT_W)) u_ch_b (
      .CLK    (CLK),
      .RST_n  (RST_n),
      .i_duty (DUTY_B_Qin),
      .i_cnt  (r_cnt),
      .i_load (w_load),
      .i_idle (w_idle),
      .o_pwm  (PWM_B)
   );

endmodule

// File: tb/tb_rgb_pwm_gen.sv
// tb_rgb_pwm_gen: self-checking bench for rgb_pwm_gen.
// Reference model tracks each period as a start cycle plus latched
// period/duty values and derives outputs from the position in the period.
module tb_rgb_pwm_gen;

   localparam int CNT_W = 32;
`ifdef RGB_PWM_ACTIVE_LOW_EN
   localparam logic ACT = 1'b0;
`else
   localparam logic ACT = 1'b1;
`endif
   localparam logic INACT = ~ACT;
   localparam logic [3:0] IDLE_VEC = {INACT, INACT, INACT, 1'b0};

   logic             CLK = 1'b0;
   logic             RST_n;
   logic [CNT_W-1:0] PERIOD_Qin;
   logic [CNT_W-1:0] DUTY_R_Qin;
   logic [CNT_W-1:0] DUTY_G_Qin;
   logic [CNT_W-1:0] DUTY_B_Qin;
   logic             PWM_R;
   logic             PWM_G;
   logic             PWM_B;
   logic             PERIOD_TICK;

   int n_cmp = 0;
   int n_err = 0;

   always #5 CLK = ~CLK;

   rgb_pwm_gen #(.CNT_W(CNT_W)) dut (
      .CLK         (CLK),
      .RST_n       (RST_n),
      .PERIOD_Qin  (PERIOD_Qin),
      .DUTY_R_Qin  (DUTY_R_Qin),
      .DUTY_G_Qin  (DUTY_G_Qin),
      .DUTY_B_Qin  (DUTY_B_Qin),
      .PWM_R       (PWM_R),
      .PWM_G       (PWM_G),
      .PWM_B       (PWM_B),
      .PERIOD_TICK (PERIOD_TICK)
   );

   wire [3:0] dut_vec = {PWM_R, PWM_G, PWM_B, PERIOD_TICK};

   // ---------------- reference model ----------------
   longint     cyc = 0;
   longint     m_start = 0;
   longint     m_per = 0;
   longint     m_dr = 0, m_dg = 0, m_db = 0;
   logic [3:0] m_vec = IDLE_VEC;

   function automatic logic lvl(input logic on);
      return on ? ACT : INACT;
   endfunction

   // Position within the running period; period ends when it reaches m_per-1
   always @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         m_per <= 0;
         m_dr  <= 0;
         m_dg  <= 0;
         m_db  <= 0;
         m_vec <= IDLE_VEC;
      end else begin
         cyc <= cyc + 1;
         if (m_per == 0) begin
            m_vec   <= IDLE_VEC;
            m_per   <= {32'd0, PERIOD_Qin};
            m_dr    <= {32'd0, DUTY_R_Qin};
            m_dg    <= {32'd0, DUTY_G_Qin};
            m_db    <= {32'd0, DUTY_B_Qin};
            m_start <= cyc + 1;
         end else begin
            m_vec <= {lvl((cyc - m_start) < m_dr), lvl((cyc - m_start) < m_dg),
                      lvl((cyc - m_start) < m_db), ((cyc - m_start) == m_per - 1)};
            if ((cyc - m_start) == m_per - 1) begin
               m_per   <= {32'd0, PERIOD_Qin};
               m_dr    <= {32'd0, DUTY_R_Qin};
               m_dg    <= {32'd0, DUTY_G_Qin};
               m_db    <= {32'd0, DUTY_B_Qin};
               m_start <= cyc + 1;
            end
         end
      end
   end

   // ---------------- tests ----------------
   task automatic test_reset();
      RST_n      = 1'b0;
      PERIOD_Qin = 32'd7;
      DUTY_R_Qin = 32'd3;
      DUTY_G_Qin = 32'd3;
      DUTY_B_Qin = 32'd3;
      for (int i = 0; i < 3; i++) begin
         @(negedge CLK);
         n_cmp++;
         if (dut_vec !== IDLE_VEC) begin
            n_err++;
            $display("FAIL reset_hold got=%b exp=%b", dut_vec, IDLE_VEC);
         end
      end
      PERIOD_Qin = '0;
      DUTY_R_Qin = '0;
      DUTY_G_Qin = '0;
      DUTY_B_Qin = '0;
      RST_n      = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge CLK);
         n_cmp++;
         if (dut_vec !== IDLE_VEC) begin
            n_err++;
            $display("FAIL reset_idle got=%b exp=%b", dut_vec, IDLE_VEC);
         end
      end
   endtask

   task automatic test_basic();
      int rc, gc, bc, tc;
      rc = 0; gc = 0; bc = 0; tc = 0;
      PERIOD_Qin = 32'd10;
      DUTY_R_Qin = 32'd3;
      DUTY_G_Qin = 32'd0;
      DUTY_B_Qin = 32'd10;
      @(negedge CLK);
      n_cmp++;
      if (PWM_R !== INACT) begin
         n_err++;
         $display("FAIL basic_first_edge R=%b exp=%b", PWM_R, INACT);
      end
      @(negedge CLK);
      n_cmp++;
      if (PWM_R !== ACT) begin
         n_err++;
         $display("FAIL basic_second_edge R=%b exp=%b", PWM_R, ACT);
      end
      for (int i = 0; i < 10; i++) begin
         @(negedge CLK);
         rc += (PWM_R == ACT) ? 1 : 0;
         gc += (PWM_G == ACT) ? 1 : 0;
         bc += (PWM_B == ACT) ? 1 : 0;
         tc += PERIOD_TICK ? 1 : 0;
         n_cmp++;
         if (dut_vec !== m_vec) begin
            n_err++;
            $display("FAIL basic_model cyc=%0d got=%b exp=%b", cyc, dut_vec, m_vec);
         end
      end
      n_cmp++;
      if ({rc, gc, bc, tc} !== {32'd3, 32'd0, 32'd10, 32'd1}) begin
         n_err++;
         $display("FAIL basic_counts got r=%0d g=%0d b=%0d t=%0d exp r=3 g=0 b=10 t=1", rc, gc, bc, tc);
      end
   endtask

   task automatic test_mid_change();
      int  c_old, c_new;
      bit  found;
      c_old = 0; c_new = 0; found = 0;
      for (int i = 0; i < 30 && !found; i++) begin
         if (m_per == 10 && (cyc - m_start) == 4) found = 1;
         else @(negedge CLK);
      end
      n_cmp++;
      if (!found) begin
         n_err++;
         $display("FAIL mid_wait got=timeout exp=cnt4");
      end
      DUTY_R_Qin = 32'd7;
      for (int k = 1; k <= 16; k++) begin
         @(negedge CLK);
         if (k <= 6) c_old += (PWM_R == ACT) ? 1 : 0;
         else        c_new += (PWM_R == ACT) ? 1 : 0;
         n_cmp++;
         if (dut_vec !== m_vec) begin
            n_err++;
            $display("FAIL mid_model cyc=%0d got=%b exp=%b", cyc, dut_vec, m_vec);
         end
      end
      n_cmp++;
      if (c_old !== 0 || c_new !== 7) begin
         n_err++;
         $display("FAIL mid_counts got old=%0d new=%0d exp old=0 new=7", c_old, c_new);
      end
   endtask

   task automatic test_period_zero();
      bit found;
      found = 0;
      for (int i = 0; i < 30 && !found; i++) begin
         if (m_per == 10 && (cyc - m_start) == 3) found = 1;
         else @(negedge CLK);
      end
      n_cmp++;
      if (!found) begin
         n_err++;
         $display("FAIL zero_wait got=timeout exp=cnt3");
      end
      PERIOD_Qin = '0;
      for (int i = 0; i < 12; i++) begin
         @(negedge CLK);
         n_cmp++;
         if (dut_vec !== m_vec) begin
            n_err++;
            $display("FAIL zero_model cyc=%0d got=%b exp=%b", cyc, dut_vec, m_vec);
         end
      end
      for (int i = 0; i < 5; i++) begin
         @(negedge CLK);
         n_cmp++;
         if (dut_vec !== IDLE_VEC) begin
            n_err++;
            $display("FAIL zero_idle got=%b exp=%b", dut_vec, IDLE_VEC);
         end
      end
   endtask

   task automatic test_period_one();
      PERIOD_Qin = 32'd1;
      DUTY_R_Qin = 32'd1;
      DUTY_G_Qin = 32'd0;
      DUTY_B_Qin = 32'd5;
      for (int i = 0; i < 2; i++) begin
         @(negedge CLK);
         n_cmp++;
         if (dut_vec !== m_vec) begin
            n_err++;
            $display("FAIL one_model cyc=%0d got=%b exp=%b", cyc, dut_vec, m_vec);
         end
      end
      for (int i = 0; i < 8; i++) begin
         @(negedge CLK);
         n_cmp++;
         if (dut_vec !== {ACT, INACT, ACT, 1'b1}) begin
            n_err++;
            $display("FAIL one_const got=%b exp=%b", dut_vec, {ACT, INACT, ACT, 1'b1});
         end
      end
   endtask

   task automatic test_saturation();
      PERIOD_Qin = 32'd5;
      DUTY_R_Qin = 32'hFFFF_FFFF;
      DUTY_G_Qin = 32'hFFFF_FFFF;
      DUTY_B_Qin = 32'hFFFF_FFFF;
      for (int i = 0; i < 2; i++) begin
         @(negedge CLK);
         n_cmp++;
         if (dut_vec !== m_vec) begin
            n_err++;
            $display("FAIL sat_model cyc=%0d got=%b exp=%b", cyc, dut_vec, m_vec);
         end
      end
      for (int i = 0; i < 15; i++) begin
         @(negedge CLK);
         n_cmp++;
         if ({PWM_R, PWM_G, PWM_B} !== {ACT, ACT, ACT} || PERIOD_TICK !== m_vec[0]) begin
            n_err++;
            $display("FAIL sat_const got=%b exp=%b%b%b%b", dut_vec, ACT, ACT, ACT, m_vec[0]);
         end
      end
   endtask

   task automatic test_reset_mid();
      bit found;
      found = 0;
      PERIOD_Qin = 32'd10;
      DUTY_R_Qin = 32'd3;
      DUTY_G_Qin = 32'd0;
      DUTY_B_Qin = 32'd10;
      for (int i = 0; i < 40 && !found; i++) begin
         @(negedge CLK);
         if (m_per == 10 && (cyc - m_start) == 6) found = 1;
      end
      n_cmp++;
      if (!found) begin
         n_err++;
         $display("FAIL rstmid_wait got=timeout exp=cnt6");
      end
      #1 RST_n = 1'b0;
      #1;
      n_cmp++;
      if (dut_vec !== IDLE_VEC) begin
         n_err++;
         $display("FAIL rstmid_async got=%b exp=%b", dut_vec, IDLE_VEC);
      end
      @(negedge CLK);
      n_cmp++;
      if (dut_vec !== IDLE_VEC) begin
         n_err++;
         $display("FAIL rstmid_hold got=%b exp=%b", dut_vec, IDLE_VEC);
      end
      RST_n = 1'b1;
      @(negedge CLK);
      n_cmp++;
      if (dut_vec !== IDLE_VEC) begin
         n_err++;
         $display("FAIL rstmid_restart1 got=%b exp=%b", dut_vec, IDLE_VEC);
      end
      @(negedge CLK);
      n_cmp++;
      if (dut_vec !== {ACT, INACT, ACT, 1'b0}) begin
         n_err++;
         $display("FAIL rstmid_restart2 got=%b exp=%b", dut_vec, {ACT, INACT, ACT, 1'b0});
      end
      for (int i = 0; i < 12; i++) begin
         @(negedge CLK);
         n_cmp++;
         if (dut_vec !== m_vec) begin
            n_err++;
            $display("FAIL rstmid_model cyc=%0d got=%b exp=%b", cyc, dut_vec, m_vec);
         end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         @(negedge CLK);
         n_cmp++;
         if (dut_vec !== m_vec) begin
            n_err++;
            $display("FAIL random_model cyc=%0d got=%b exp=%b", cyc, dut_vec, m_vec);
         end
         if ($urandom_range(0, 7) == 0) begin
            case ($urandom_range(0, 3))
               0: PERIOD_Qin = 32'($urandom_range(0, 12));
               1: DUTY_R_Qin = ($urandom_range(0, 5) == 0) ? 32'hFFFF_FFFF : 32'($urandom_range(0, 14));
               2: DUTY_G_Qin = ($urandom_range(0, 5) == 0) ? 32'hFFFF_FFFF : 32'($urandom_range(0, 14));
               default: DUTY_B_Qin = 32'($urandom_range(0, 14));
            endcase
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_mid_change();
      test_period_zero();
      test_period_one();
      test_saturation();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
